// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu internal data bus: source select encoding,
// arbiter states and one-hot grant helpers.
package mycpu_pkg;

   localparam int unsigned BUS_SRCS = 3;

   typedef enum logic [1:0] {
      SRC0 = 2'b00,
      SRC1 = 2'b01,
      SRC2 = 2'b11
   } bus_src_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   // Bus select encoding for a one-hot grant; 2'b10 is never produced.
   function automatic bus_src_t src_of(input logic [BUS_SRCS-1:0] oh);
      bus_src_t src;
      src = SRC0;
      if (oh[1]) src = SRC1;
      if (oh[2]) src = SRC2;
      return src;
   endfunction

   function automatic logic [1:0] ptr_of(input logic [BUS_SRCS-1:0] oh);
      logic [1:0] ptr;
      ptr = 2'd0;
      if (oh[1]) ptr = 2'd1;
      if (oh[2]) ptr = 2'd2;
      return ptr;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters; the source after
// last_ptr has highest priority and last_ptr itself the lowest.
module rr_pick3
   import mycpu_pkg::*;
(
   input  logic [BUS_SRCS-1:0] req,
   input  logic [1:0]          last_ptr,
   output logic [BUS_SRCS-1:0] win,
   output logic                valid
);

   always_comb begin
      win   = '0;
      valid = |req;
      case (last_ptr)
         2'd0: begin
            if      (req[1]) win = 3'b010;
            else if (req[2]) win = 3'b100;
            else if (req[0]) win = 3'b001;
         end
         2'd1: begin
            if      (req[2]) win = 3'b100;
            else if (req[0]) win = 3'b001;
            else if (req[1]) win = 3'b010;
         end
         default: begin
            if      (req[0]) win = 3'b001;
            else if (req[1]) win = 3'b010;
            else if (req[2]) win = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/bus_arbiter_3x16.sv
// Round-robin arbiter and sequencer for the shared 3-source internal data bus:
// grants one source at a time, bounds its tenure under contention, registers its word.
module bus_arbiter_3x16
   import mycpu_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned DATA_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BUS_SRCS-1:0] req_in,
   input  logic [DATA_W-1:0]   d0_in,
   input  logic [DATA_W-1:0]   d1_in,
   input  logic [DATA_W-1:0]   d2_in,
   output logic [BUS_SRCS-1:0] grant_out,
   output logic [1:0]          sel_out,
   output logic [DATA_W-1:0]   bus_out,
   output logic                bus_valid_out,
   output logic                busy_out
);

   localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t          state_q, state_d;
   logic [BUS_SRCS-1:0] grant_q, grant_d;
   bus_src_t            sel_q, sel_d;
   logic [1:0]          last_ptr_q, last_ptr_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0]   bus_q, bus_d;
   logic                bus_valid_q, bus_valid_d;
   logic                busy_q, busy_d;

   logic [BUS_SRCS-1:0] pick_win;
   logic                pick_valid;
   logic                keep_c;
   logic                others_c;
   logic                new_grant_c;

   // last_ptr always names the granted source, so it is also the lowest
   // priority candidate: a forced hand-over can never re-pick the holder.
   rr_pick3 u_pick (
      .req      (req_in),
      .last_ptr (last_ptr_q),
      .win      (pick_win),
      .valid    (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         sel_q       <= SRC0;
         last_ptr_q  <= 2'd2;
         hold_cnt_q  <= '0;
         bus_q       <= '0;
         bus_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         last_ptr_q  <= last_ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         bus_q       <= bus_d;
         bus_valid_q <= bus_valid_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      last_ptr_d  = last_ptr_q;
      hold_cnt_d  = hold_cnt_q;
      bus_d       = bus_q;
      bus_valid_d = 1'b0;
      new_grant_c = 1'b0;
      keep_c      = |(req_in & grant_q);
      others_c    = |(req_in & ~grant_q);

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) new_grant_c = 1'b1;
         end
         ARB_GRANT: begin
            if (!keep_c) begin
               if (pick_valid) begin
                  new_grant_c = 1'b1;
               end else begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
               end
            end else if (others_c && (hold_cnt_q == HOLD_LAST)) begin
               new_grant_c = 1'b1;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase

      if (new_grant_c) begin
         state_d    = ARB_GRANT;
         grant_d    = pick_win;
         sel_d      = src_of(pick_win);
         last_ptr_d = ptr_of(pick_win);
         hold_cnt_d = '0;
      end

      // The word moves with the grant that was already visible this cycle.
      if (keep_c) begin
         bus_valid_d = 1'b1;
         if (grant_q[0])      bus_d = d0_in;
         else if (grant_q[1]) bus_d = d1_in;
         else                 bus_d = d2_in;
      end

      busy_d = |grant_d;
   end

   assign grant_out     = grant_q;
   assign sel_out       = sel_q;
   assign bus_out       = bus_q;
   assign bus_valid_out = bus_valid_q;
   assign busy_out      = busy_q;

endmodule
